fifo_wr_ctrl: RTL

Write-side controller of the asynchronous width-converting FIFO. It sits directly upstream of `fifo_rd_ctrl`, in the write clock domain. It owns the write pointer and the RAM write enable. It publishes a Gray-coded write pointer for the read domain to synchronise. It also synchronises the read domain's Gray pointer and uses it to derive the full flag and the write-side fill count.

---
 rtl/fifo_pkg.sv | 27 ++
 rtl/ptr_sync_2ff.sv | 27 ++
 rtl/fifo_wr_ctrl.sv | 68 ++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: Gray/binary conversion and
// pointer-width derivation, used by both the write and the read controllers.
package fifo_pkg;

    localparam int MAX_PTR_W = 32;

    typedef logic [MAX_PTR_W-1:0] ptr_word_t;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic ptr_word_t bin2gray(input ptr_word_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Upper zero bits contribute nothing, so narrower pointers can be zero-extended in.
    function automatic ptr_word_t gray2bin(input ptr_word_t gray);
        ptr_word_t bin;
        bin[MAX_PTR_W-1] = gray[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/ptr_sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
module ptr_sync_2ff #(
    parameter int WIDTH = 6
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so r_sync takes the old r_meta.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async width-converting FIFO: owns the write pointer,
// publishes its Gray code, and derives full/count from the synchronised read pointer.
module fifo_wr_ctrl
    import fifo_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = 5,
    parameter int WR_IND         = 1,
    parameter int WR_CNT_WIDTH   = RAM_ADDR_WIDTH + 1 - $clog2(WR_IND)
) (
    input  logic                      wr_clk,
    input  logic                      wr_rst,
    input  logic                      wr_en,
    input  logic [RAM_ADDR_WIDTH:0]   rd_ptr_gray,
    output logic [RAM_ADDR_WIDTH:0]   wr_ptr,
    output logic [RAM_ADDR_WIDTH:0]   wr_ptr_gray,
    output logic                      fifo_full,
    output logic [WR_CNT_WIDTH-1:0]   wr_data_count,
    output logic                      ram_wr_en
);

    localparam int PTR_W    = ptr_width(RAM_ADDR_WIDTH);
    localparam int IND_LOG2 = $clog2(WR_IND);
    localparam logic [PTR_W-1:0] PTR_INC    = PTR_W'(WR_IND);
    localparam logic [PTR_W-1:0] FULL_LIMIT = PTR_W'((1 << RAM_ADDR_WIDTH) - WR_IND);

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_wr_ptr_gray;
    logic [PTR_W-1:0] w_rd_gray_sync;
    logic [PTR_W-1:0] w_rd_ptr_sync;
    logic [PTR_W-1:0] w_wr_ptr_next;
    logic [PTR_W-1:0] w_diff;
    logic             w_full;
    logic             w_wr_accept;

    ptr_sync_2ff #(
        .WIDTH (PTR_W)
    ) u_rd_ptr_sync (
        .i_clk (wr_clk),
        .i_rst (wr_rst),
        .i_d   (rd_ptr_gray),
        .o_q   (w_rd_gray_sync)
    );

    // The synchronised read pointer lags the real one, so full/count err on the full side.
    assign w_rd_ptr_sync = PTR_W'(gray2bin(ptr_word_t'(w_rd_gray_sync)));
    assign w_diff        = r_wr_ptr - w_rd_ptr_sync;
    assign w_full        = (w_diff > FULL_LIMIT);
    assign w_wr_accept   = wr_en & ~w_full;
    assign w_wr_ptr_next = r_wr_ptr + PTR_INC;

    // Gray register loads from the same next value as the binary one, keeping them paired.
    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            r_wr_ptr      <= '0;
            r_wr_ptr_gray <= '0;
        end else if (w_wr_accept) begin
            r_wr_ptr      <= w_wr_ptr_next;
            r_wr_ptr_gray <= PTR_W'(bin2gray(ptr_word_t'(w_wr_ptr_next)));
        end
    end

    assign wr_ptr        = r_wr_ptr;
    assign wr_ptr_gray   = r_wr_ptr_gray;
    assign fifo_full     = w_full;
    assign wr_data_count = w_diff[PTR_W-1:IND_LOG2];
    assign ram_wr_en     = w_wr_accept;

endmodule
